// File: rtl/id_ex_operand_stage_if.sv
// Bundle of ID-side, hazard-bypass and EX-side signals for the ID/EX operand stage.
// master drives the ID/bypass inputs; slave is the pipeline register itself.
interface id_ex_operand_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  // stall/flush are level controls sampled at the rising edge; flush beats stall.
  // There is no ready path: the upstream sees a stall as "do not advance".
  logic              stall;
  logic              flush;

  logic              id_valid;
  logic [3:0]        id_alucontrol;
  logic [DATA_W-1:0] id_rsdata;
  logic [DATA_W-1:0] id_rtdata;
  logic [DATA_W-1:0] id_imm;
  logic [4:0]        id_shamt;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic              id_alusrc;
  logic              id_regwrite;
  logic              id_memread;
  logic              id_memwrite;
  logic              id_memtoreg;

  logic              mem_regwrite;
  logic [REG_AW-1:0] mem_rd;
  logic [DATA_W-1:0] mem_result;
  logic              wb_regwrite;
  logic [REG_AW-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;

  logic              ex_valid;
  logic [3:0]        ex_alucontrol;
  logic [DATA_W-1:0] ex_a;
  logic [DATA_W-1:0] ex_b;
  logic [4:0]        ex_shamt;
  logic [DATA_W-1:0] ex_storedata;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_regwrite;
  logic              ex_memread;
  logic              ex_memwrite;
  logic              ex_memtoreg;

  modport master (
    output stall, flush,
    output id_valid, id_alucontrol, id_rsdata, id_rtdata, id_imm, id_shamt,
    output id_rs, id_rt, id_rd, id_alusrc,
    output id_regwrite, id_memread, id_memwrite, id_memtoreg,
    output mem_regwrite, mem_rd, mem_result, wb_regwrite, wb_rd, wb_data,
    input  ex_valid, ex_alucontrol, ex_a, ex_b, ex_shamt, ex_storedata, ex_rd,
    input  ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg
  );

  modport slave (
    input  stall, flush,
    input  id_valid, id_alucontrol, id_rsdata, id_rtdata, id_imm, id_shamt,
    input  id_rs, id_rt, id_rd, id_alusrc,
    input  id_regwrite, id_memread, id_memwrite, id_memtoreg,
    input  mem_regwrite, mem_rd, mem_result, wb_regwrite, wb_rd, wb_data,
    output ex_valid, ex_alucontrol, ex_a, ex_b, ex_shamt, ex_storedata, ex_rd,
    output ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, stall, flush and
// stall-time capture of values retiring from WB.
module id_ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  id_ex_operand_stage_if.slave bus
);

  logic              valid_q;
  logic [3:0]        alucontrol_q;
  logic [DATA_W-1:0] rsdata_q;
  logic [DATA_W-1:0] rtdata_q;
  logic [DATA_W-1:0] imm_q;
  logic [4:0]        shamt_q;
  logic [REG_AW-1:0] rs_q;
  logic [REG_AW-1:0] rt_q;
  logic [REG_AW-1:0] rd_q;
  logic              alusrc_q;
  logic              regwrite_q;
  logic              memread_q;
  logic              memwrite_q;
  logic              memtoreg_q;

  logic wb_hit_rs;
  logic wb_hit_rt;
  logic mem_hit_rs;
  logic mem_hit_rt;

  // Register 0 is hardwired, so a write to it is never a producer.
  assign wb_hit_rs  = bus.wb_regwrite  && (bus.wb_rd  != '0) && (bus.wb_rd  == rs_q);
  assign wb_hit_rt  = bus.wb_regwrite  && (bus.wb_rd  != '0) && (bus.wb_rd  == rt_q);
  assign mem_hit_rs = bus.mem_regwrite && (bus.mem_rd != '0) && (bus.mem_rd == rs_q);
  assign mem_hit_rt = bus.mem_regwrite && (bus.mem_rd != '0) && (bus.mem_rd == rt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      alucontrol_q <= '0;
      rsdata_q     <= '0;
      rtdata_q     <= '0;
      imm_q        <= '0;
      shamt_q      <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      alusrc_q     <= 1'b0;
      regwrite_q   <= 1'b0;
      memread_q    <= 1'b0;
      memwrite_q   <= 1'b0;
      memtoreg_q   <= 1'b0;
    end else if (bus.flush) begin
      valid_q      <= 1'b0;
      alucontrol_q <= '0;
      rsdata_q     <= '0;
      rtdata_q     <= '0;
      imm_q        <= '0;
      shamt_q      <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      alusrc_q     <= 1'b0;
      regwrite_q   <= 1'b0;
      memread_q    <= 1'b0;
      memwrite_q   <= 1'b0;
      memtoreg_q   <= 1'b0;
    end else if (bus.stall) begin
      // A value retiring from WB while held would otherwise be lost once WB moves on.
      if (wb_hit_rs) rsdata_q <= bus.wb_data;
      if (wb_hit_rt) rtdata_q <= bus.wb_data;
    end else begin
      valid_q      <= bus.id_valid;
      alucontrol_q <= bus.id_alucontrol;
      rsdata_q     <= bus.id_rsdata;
      rtdata_q     <= bus.id_rtdata;
      imm_q        <= bus.id_imm;
      shamt_q      <= bus.id_shamt;
      rs_q         <= bus.id_rs;
      rt_q         <= bus.id_rt;
      rd_q         <= bus.id_rd;
      alusrc_q     <= bus.id_alusrc;
      regwrite_q   <= bus.id_regwrite & bus.id_valid;
      memread_q    <= bus.id_memread  & bus.id_valid;
      memwrite_q   <= bus.id_memwrite & bus.id_valid;
      memtoreg_q   <= bus.id_memtoreg & bus.id_valid;
    end
  end

  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  // MEM is the younger producer, so it wins over WB.
  always_comb begin
    fwd_rs = rsdata_q;
    if (mem_hit_rs)     fwd_rs = bus.mem_result;
    else if (wb_hit_rs) fwd_rs = bus.wb_data;

    fwd_rt = rtdata_q;
    if (mem_hit_rt)     fwd_rt = bus.mem_result;
    else if (wb_hit_rt) fwd_rt = bus.wb_data;
  end

  assign bus.ex_valid      = valid_q;
  assign bus.ex_alucontrol = alucontrol_q;
  assign bus.ex_a          = fwd_rs;
  assign bus.ex_b          = alusrc_q ? imm_q : fwd_rt;
  assign bus.ex_shamt      = shamt_q;
  assign bus.ex_storedata  = fwd_rt;
  assign bus.ex_rd         = rd_q;
  assign bus.ex_regwrite   = regwrite_q;
  assign bus.ex_memread    = memread_q;
  assign bus.ex_memwrite   = memwrite_q;
  assign bus.ex_memtoreg   = memtoreg_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: reset, load, forwarding, R0, stall capture,
// flush, immediate select and reset during stall.
module tb_id_ex_operand_stage;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  id_ex_operand_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

  id_ex_operand_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall         = 1'b0;
    bus.flush         = 1'b0;
    bus.id_valid      = 1'b0;
    bus.id_alucontrol = 4'd0;
    bus.id_rsdata     = '0;
    bus.id_rtdata     = '0;
    bus.id_imm        = '0;
    bus.id_shamt      = 5'd0;
    bus.id_rs         = '0;
    bus.id_rt         = '0;
    bus.id_rd         = '0;
    bus.id_alusrc     = 1'b0;
    bus.id_regwrite   = 1'b0;
    bus.id_memread    = 1'b0;
    bus.id_memwrite   = 1'b0;
    bus.id_memtoreg   = 1'b0;
    bus.mem_regwrite  = 1'b0;
    bus.mem_rd        = '0;
    bus.mem_result    = '0;
    bus.wb_regwrite   = 1'b0;
    bus.wb_rd         = '0;
    bus.wb_data       = '0;
  endtask

  task automatic drive_r(input logic [3:0] alu, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd);
    bus.id_valid      = 1'b1;
    bus.id_alucontrol = alu;
    bus.id_rs         = rs;
    bus.id_rt         = rt;
    bus.id_rd         = rd;
    bus.id_rsdata     = rsd;
    bus.id_rtdata     = rtd;
    bus.id_alusrc     = 1'b0;
    bus.id_regwrite   = 1'b1;
    bus.id_memread    = 1'b0;
    bus.id_memwrite   = 1'b0;
    bus.id_memtoreg   = 1'b0;
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    idle_inputs();

    // 1: reset with busy inputs
    rst_n = 1'b0;
    drive_r(4'd2, 5'd8, 5'd9, 5'd10, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    bus.id_memwrite  = 1'b1;
    bus.mem_regwrite = 1'b1;
    bus.mem_rd       = 5'd5;
    bus.mem_result   = 32'h1111_1111;
    #3;
    @(posedge clk);
    #1;
    chk("rst_valid",    {31'd0, bus.ex_valid}, 32'd0);
    chk("rst_alu",      {28'd0, bus.ex_alucontrol}, 32'd0);
    chk("rst_a",        bus.ex_a, 32'd0);
    chk("rst_b",        bus.ex_b, 32'd0);
    chk("rst_store",    bus.ex_storedata, 32'd0);
    chk("rst_rd",       {27'd0, bus.ex_rd}, 32'd0);
    chk("rst_ctl",      {28'd0, bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite, bus.ex_memtoreg}, 32'd0);

    idle_inputs();
    rst_n = 1'b1;
    drive_r(4'd2, 5'd8, 5'd9, 5'd10, 32'd5, 32'd7);
    tick();
    chk("load_valid",   {31'd0, bus.ex_valid}, 32'd1);
    chk("load_a",       bus.ex_a, 32'd5);
    chk("load_b",       bus.ex_b, 32'd7);
    chk("load_rd",      {27'd0, bus.ex_rd}, 32'd10);
    chk("load_alu",     {28'd0, bus.ex_alucontrol}, 32'd2);
    chk("load_regwr",   {31'd0, bus.ex_regwrite}, 32'd1);

    // 2: MEM beats WB, then WB alone, then none
    drive_r(4'd2, 5'd3, 5'd9, 5'd11, 32'h33, 32'd7);
    tick();
    bus.mem_regwrite = 1'b1;
    bus.mem_rd       = 5'd3;
    bus.mem_result   = 32'h11;
    bus.wb_regwrite  = 1'b1;
    bus.wb_rd        = 5'd3;
    bus.wb_data      = 32'h22;
    #1;
    chk("fwd_mem_prio", bus.ex_a, 32'h11);
    bus.mem_regwrite = 1'b0;
    #1;
    chk("fwd_wb",       bus.ex_a, 32'h22);
    bus.wb_regwrite  = 1'b0;
    #1;
    chk("fwd_none",     bus.ex_a, 32'h33);

    // 3: register 0 never forwarded
    drive_r(4'd2, 5'd0, 5'd9, 5'd12, 32'h55, 32'd7);
    tick();
    bus.mem_regwrite = 1'b1;
    bus.mem_rd       = 5'd0;
    bus.mem_result   = 32'hFF;
    bus.wb_regwrite  = 1'b1;
    bus.wb_rd        = 5'd0;
    bus.wb_data      = 32'hEE;
    #1;
    chk("r0_no_fwd",    bus.ex_a, 32'h55);
    idle_inputs();

    // 4: capture a WB value while stalled
    drive_r(4'd0, 5'd8, 5'd4, 5'd13, 32'd5, 32'd1);
    tick();
    chk("hold_b_pre",   bus.ex_b, 32'd1);
    bus.stall = 1'b1;
    drive_r(4'd1, 5'd14, 5'd15, 5'd20, 32'hBB, 32'hAA);
    bus.wb_regwrite = 1'b1;
    bus.wb_rd       = 5'd4;
    bus.wb_data     = 32'd9;
    #1;
    chk("stall_fwd_b",  bus.ex_b, 32'd9);
    tick();
    bus.wb_regwrite = 1'b0;
    bus.wb_data     = 32'd0;
    #1;
    chk("capture_b",    bus.ex_b, 32'd9);
    chk("stall_hold_a", bus.ex_a, 32'd5);
    chk("stall_hold_rd", {27'd0, bus.ex_rd}, 32'd13);
    tick();
    chk("capture_keep", bus.ex_b, 32'd9);
    bus.stall = 1'b0;
    tick();
    chk("release_a",    bus.ex_a, 32'hBB);
    chk("release_b",    bus.ex_b, 32'hAA);
    chk("release_rd",   {27'd0, bus.ex_rd}, 32'd20);

    // 5: flush and stall together with a valid store
    drive_r(4'd2, 5'd16, 5'd17, 5'd0, 32'h77, 32'h88);
    bus.id_memwrite = 1'b1;
    bus.stall       = 1'b1;
    bus.flush       = 1'b1;
    tick();
    chk("flush_valid",  {31'd0, bus.ex_valid}, 32'd0);
    chk("flush_memwr",  {31'd0, bus.ex_memwrite}, 32'd0);
    chk("flush_regwr",  {31'd0, bus.ex_regwrite}, 32'd0);
    chk("flush_a",      bus.ex_a, 32'd0);
    bus.stall = 1'b0;
    bus.flush = 1'b0;

    // invalid slot: control bits masked
    drive_r(4'd3, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2);
    bus.id_valid    = 1'b0;
    bus.id_memread  = 1'b1;
    bus.id_memtoreg = 1'b1;
    tick();
    chk("inv_ctl",      {27'd0, bus.ex_valid, bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite, bus.ex_memtoreg}, 32'd0);
    chk("inv_alu",      {28'd0, bus.ex_alucontrol}, 32'd3);

    // 6: immediate B with forwarded store data
    drive_r(4'd2, 5'd8, 5'd6, 5'd0, 32'd2, 32'd1);
    bus.id_alusrc   = 1'b1;
    bus.id_imm      = 32'hFFFF_FFF0;
    bus.id_shamt    = 5'd7;
    bus.id_regwrite = 1'b0;
    bus.id_memwrite = 1'b1;
    tick();
    bus.mem_regwrite = 1'b1;
    bus.mem_rd       = 5'd6;
    bus.mem_result   = 32'h1234;
    #1;
    chk("imm_b",        bus.ex_b, 32'hFFFF_FFF0);
    chk("imm_store",    bus.ex_storedata, 32'h1234);
    chk("imm_shamt",    {27'd0, bus.ex_shamt}, 32'd7);
    chk("imm_memwr",    {31'd0, bus.ex_memwrite}, 32'd1);

    // reset asserted mid-stall takes effect without a clock edge
    bus.stall = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_stall_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("rst_stall_memwr", {31'd0, bus.ex_memwrite}, 32'd0);
    chk("rst_stall_b",     bus.ex_b, 32'd0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
